series_ctrl: RTL and testbench
==============================

# series_ctrl

- Control FSM for the Q2.8 series-evaluation datapath (cos/cosh by Taylor terms).
- Sits directly upstream of the datapath and drives all of its control inputs:
  - register inits and loads, the multiplier operand select, the LUT-address counter and the add/subtract select.
- Consumes the datapath status flags `co` (counter at 15) and `gt` (new term below threshold `y`).
- Exposes a start/busy/done handshake to the system.

## Interface
Parameters: none (widths fixed by the datapath).

- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — synchronous, active-low reset.
- `start` input 1 — request an evaluation; sampled only in IDLE.
- `mode` input 1 — 0: alternating signs (cos); 1: all terms added (cosh). Latched in INIT.
- `co` input 1 — datapath counter carry, combinational `&adr`.
- `gt` input 1 — datapath flag, high when the candidate term is less than `{2'b00,y}`.
- `initr`, `initt` output 1 each — load 0x100 into the result and term registers.
- `zc` output 1 — clear the LUT-address counter.
- `ldx` output 1 — load x² into the x² register.
- `s` output 1 — multiplier operand select: 1 = x², 0 = LUT coefficient.
- `ldt` output 1 — load the term register.
- `enc` output 1 — increment the LUT-address counter.
- `ldr` output 1 — load the result register.
- `is_neg` output 1 — subtract the term when 1, add when 0.
- `busy` output 1 — high in every state except IDLE.
- `done` output 1 — one-cycle pulse; the result is valid in the same cycle.

## Operation
- States: IDLE, INIT, MULX, MULC, ACC, DONE. Encoding is free. Outputs are Moore, except the MULC/ACC exit decisions.
- Internal `sign` flip-flop and latched `mode_q`.
- IDLE: all controls 0, `busy`=0. If `start`=1 → INIT, otherwise stay.
- INIT: `initr`=`initt`=`zc`=`ldx`=1.
  - `sign`←1, `mode_q`←`mode`.
  - `x` must be stable in this cycle; it is not used again.
  - → MULX.
- MULX: `s`=1, `ldt`=1, so term ← term·x². → MULC.
- MULC: `s`=0, `ldt`=1, so term ← term·LUT[adr].
  - If `gt`=1 → DONE. The term was loaded but is never accumulated.
  - Otherwise → ACC.
- ACC: `ldr`=1, `enc`=1, `is_neg` = `sign & ~mode_q`.
  - `sign` toggles.
  - If `co`=1, sampled before the increment (adr=15) → DONE; the counter wraps to 0, which is harmless.
  - Otherwise → MULX.
- DONE: `done`=1, `busy`=1, all other controls 0. → IDLE unconditionally.
- `start` outside IDLE is ignored and not queued. `start` held high re-triggers an evaluation on the cycle after DONE.
- Simultaneous `gt` and `co` cannot matter: `gt` is only examined in MULC and `co` only in ACC.
- At most one of `initt`/`ldt` and one of `initr`/`ldr` is high in any cycle.

## Timing
- Reset (`rst`=0 at a rising edge) forces IDLE, `sign`=0 and `mode_q`=0, with all outputs 0 from the next cycle.
  - This applies mid-evaluation too: `done` is not issued. The datapath keeps its partial contents until the next INIT.
- Let `start` be sampled at edge N. Then INIT runs in cycle N+1 and MULX in N+2.
- Evaluation with k accumulated terms, terminated by `gt`: `done` is in cycle N+1+3k+3.
  - Total cycles in states other than IDLE: 3k+4.
- Terminated by `co` (k=16): `done` is in cycle N+50, `busy` high for 50 cycles.
- Minimum (k=0): `done` at N+4. `busy` rises at N+1 and falls after the DONE cycle.

## Test plan
- x=0, y=1, mode=0, pulse `start` → INIT, MULX, MULC, DONE. `gt`=1 at MULC, no `ldr`. `done` at N+4, res=0x100.
- y=0, any x, mode=0 → `gt` is never 1. Exactly 16 `ldr`/`enc` pulses; `is_neg` pattern 1,0,1,0,… `done` at N+50.
- Same as the previous case with mode=1 → `is_neg`=0 on all 16 ACC cycles. `mode` changed after INIT has no effect.
- Force `gt`=1 on the 3rd MULC → exactly 2 ACC cycles, `done` at N+1+6+3 = N+10, `busy` falls the next cycle.
- `start` pulsed while busy, then `start` held high continuously → the busy-time pulse is ignored; a new INIT follows the DONE cycle by one IDLE cycle.
- `rst`=0 during the 5th ACC → IDLE next cycle, all outputs 0, no `done`. A following `start` runs a full evaluation with `sign` restarting at 1.

Source files
------------

// File: rtl/series_ctrl_if.sv
// Control/status bundle between series_ctrl, the system and the series datapath.
// The slave side is the controller; the master side is its environment.
interface series_ctrl_if;
    // system handshake
    logic start;
    logic mode;
    logic busy;
    logic done;
    // datapath status
    logic co;
    logic gt;
    // datapath controls
    logic initr;
    logic initt;
    logic zc;
    logic ldx;
    logic s;
    logic ldt;
    logic enc;
    logic ldr;
    logic is_neg;

    modport slave (
        input  start, mode, co, gt,
        output busy, done, initr, initt, zc, ldx, s, ldt, enc, ldr, is_neg
    );

    modport master (
        output start, mode, co, gt,
        input  busy, done, initr, initt, zc, ldx, s, ldt, enc, ldr, is_neg
    );
endinterface

// File: rtl/series_ctrl.sv
// Control FSM for the Q2.8 cos/cosh Taylor-series datapath.
// Each term costs three cycles (MULX, MULC, ACC). Evaluation stops either when
// the freshly computed term falls below the threshold (gt in MULC) or after the
// last LUT coefficient has been accumulated (co in ACC).
module series_ctrl (
    input  logic          clk,
    input  logic          rst,
    series_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MULX,
        MULC,
        ACC,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic   sign_q, sign_d;
    logic   mode_q, mode_d;

    // State, sign and latched mode registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic and Moore control outputs.
    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        mode_d     = mode_q;
        bus.initr  = 1'b0;
        bus.initt  = 1'b0;
        bus.zc     = 1'b0;
        bus.ldx    = 1'b0;
        bus.s      = 1'b0;
        bus.ldt    = 1'b0;
        bus.enc    = 1'b0;
        bus.ldr    = 1'b0;
        bus.is_neg = 1'b0;
        bus.busy   = 1'b1;
        bus.done   = 1'b0;

        case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_d = INIT;
            end
            INIT: begin
                // result = term = 1.0, counter = 0, x^2 captured from x now
                bus.initr = 1'b1;
                bus.initt = 1'b1;
                bus.zc    = 1'b1;
                bus.ldx   = 1'b1;
                sign_d    = 1'b1;
                mode_d    = bus.mode;
                state_d   = MULX;
            end
            MULX: begin
                bus.s   = 1'b1;
                bus.ldt = 1'b1;
                state_d = MULC;
            end
            MULC: begin
                // term is loaded regardless; if it is already below the
                // threshold it is simply never accumulated
                bus.ldt = 1'b1;
                state_d = bus.gt ? DONE : ACC;
            end
            ACC: begin
                bus.ldr    = 1'b1;
                bus.enc    = 1'b1;
                bus.is_neg = sign_q & ~mode_q;
                sign_d     = ~sign_q;
                // co reflects adr before this increment; wrap to 0 is harmless
                state_d    = bus.co ? DONE : MULX;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_series_ctrl.sv
// Bench for series_ctrl: drives randomized evaluations (term count, mode,
// noise on ignored status inputs) and compares every cycle's control outputs
// against a timeline model derived from the per-term cycle schedule.
module tb_series_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    series_ctrl_if bus_if ();

    series_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int tests = 0;
    int fails = 0;

    // {initr,initt,zc,ldx,s,ldt,enc,ldr,is_neg,busy,done}
    function automatic logic [10:0] obs_out();
        return {bus_if.initr, bus_if.initt, bus_if.zc, bus_if.ldx, bus_if.s,
                bus_if.ldt, bus_if.enc, bus_if.ldr, bus_if.is_neg,
                bus_if.busy, bus_if.done};
    endfunction

    function automatic int done_cycle(int k);
        // k terms stopped by gt: INIT + 3k + MULX + MULC, then DONE
        // all 16 terms stopped by co: INIT + 48, then DONE
        return (k >= 16) ? 50 : 4 + 3 * k;
    endfunction

    // Expected outputs c cycles after the cycle in which start was sampled.
    function automatic logic [10:0] exp_out(int c, int k, logic m);
        int dc;
        int j;
        int ph;
        logic [10:0] e;
        dc = done_cycle(k);
        e  = '0;
        if (c == 1) begin
            e = 11'b11110000010;
        end else if (c == dc) begin
            e = 11'b00000000011;
        end else if (c >= 2 && c < dc) begin
            j  = (c - 2) / 3;
            ph = (c - 2) % 3;
            case (ph)
                0:       e = 11'b00001100010;
                1:       e = 11'b00000100010;
                default: begin
                    e = 11'b00000011010;
                    // first accumulated term (j=0) is subtracted in cos mode
                    e[2] = ((j % 2) == 0) && !m;
                end
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [10:0] e);
        logic [10:0] o;
        o = obs_out();
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: got %b want %b", tag, o, e);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            rst          = 1'b1;
            bus_if.start = 1'b0;
            bus_if.mode  = 1'($urandom);
            bus_if.gt    = 1'($urandom);
            bus_if.co    = 1'($urandom);
            @(negedge clk);
            check($sformatf("%s idle%0d", tag, i), 11'b0);
            @(posedge clk);
            #1;
        end
    endtask

    // smode: 0 single start pulse, 1 plus a pulse while busy, 2 start held high.
    // rst_at >= 0 asserts reset during that cycle and ends the evaluation.
    task automatic run_eval(input int k, input logic m, input int smode,
                            input int rst_at, input string tag);
        int  dc;
        bit  is_mulc;
        bit  is_acc;
        dc = done_cycle(k);
        for (int c = 0; c <= dc; c++) begin
            is_mulc = (c >= 3) && ((c - 3) % 3 == 0);
            is_acc  = (c >= 4) && ((c - 4) % 3 == 0);
            bus_if.start = (c == 0) || (smode == 1 && c == 2) || (smode == 2);
            bus_if.mode  = (c == 1) ? m : 1'($urandom);
            bus_if.gt    = is_mulc ? (k < 16 && c == 3 + 3 * k) : 1'($urandom);
            bus_if.co    = is_acc  ? (c == 49) : 1'($urandom);
            rst          = (c == rst_at) ? 1'b0 : 1'b1;
            @(negedge clk);
            check($sformatf("%s c=%0d", tag, c), exp_out(c, k, m));
            @(posedge clk);
            #1;
            if (c == rst_at) begin
                rst          = 1'b1;
                bus_if.start = 1'b0;
                @(negedge clk);
                check($sformatf("%s after_rst", tag), 11'b0);
                @(posedge clk);
                #1;
                return;
            end
        end
    endtask

    initial begin
        rst          = 1'b0;
        bus_if.start = 1'b0;
        bus_if.mode  = 1'b0;
        bus_if.gt    = 1'b0;
        bus_if.co    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset", 11'b0);
        @(posedge clk);
        #1;
        idle(2, "post_reset");

        // minimum evaluation: gt on first MULC, done at N+4
        run_eval(0, 1'b0, 0, -1, "min");
        idle(1, "min");

        // no gt ever: 16 terms, terminated by co, done at N+50
        run_eval(16, 1'b0, 0, -1, "co_cos");
        idle(1, "co_cos");
        run_eval(16, 1'b1, 0, -1, "co_cosh");
        idle(1, "co_cosh");

        // gt on 3rd MULC: 2 accumulated terms, done at N+10
        run_eval(2, 1'b0, 0, -1, "gt3");
        idle(1, "gt3");

        // start while busy is ignored
        run_eval(3, 1'b0, 1, -1, "busy_pulse");
        idle(2, "busy_pulse");

        // start held high: back-to-back evaluations with one IDLE in between
        run_eval(4, 1'b1, 2, -1, "held1");
        run_eval(1, 1'b0, 2, -1, "held2");
        run_eval(5, 1'b0, 0, -1, "held3");
        idle(1, "held3");

        // reset during the 5th ACC, then a clean evaluation
        run_eval(16, 1'b0, 0, 16, "rst_mid");
        idle(2, "rst_mid");
        run_eval(3, 1'b0, 0, -1, "after_rst");
        idle(1, "after_rst");

        // randomized evaluations
        for (int r = 0; r < 8; r++) begin
            int   k;
            logic m;
            int   sm;
            k  = int'($urandom_range(0, 16));
            m  = 1'($urandom);
            sm = int'($urandom_range(0, 1));
            run_eval(k, m, sm, -1, $sformatf("rnd%0d_k%0d", r, k));
            idle(1 + int'($urandom_range(0, 2)), $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
